// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: unsigned 4x4 shift-and-add multiplier. It has no adder of its own and
// time-shares one external 4-bit adder.
//
// Ports:
//   clk       system clock; all state changes on the rising edge
//   rst       asynchronous, active-high reset
//   start     multiply request; sampled only in idle
//   a, b      multiplicand and multiplier; captured on the accepting edge
//   add_a     operand A to the external adder (P[7:4] in CALC, else 0)
//   add_b     operand B to the external adder (M or 0 in CALC, else 0)
//   add_s     external adder sum (carry-in 0)
//   add_cout  external adder carry-out
//   product   last completed result, registered
//   busy      high while calculating
//   done      one-cycle completion pulse

module mult_seq_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] add_a,
    output logic [3:0] add_b,
    input  logic [3:0] add_s,
    input  logic       add_cout,
    output logic [7:0] product,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StCalc = 2'b01,
        StDone = 2'b10
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] m_q, m_d;
    logic [7:0] p_q, p_d;
    logic [1:0] cnt_q, cnt_d;
    logic [7:0] product_d;
    logic [7:0] sum_shift;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            m_q     <= 4'h0;
            p_q     <= 8'h00;
            cnt_q   <= 2'd0;
            product <= 8'h00;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            product <= product_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        p_d       = p_q;
        cnt_d     = cnt_q;
        product_d = product;
        add_a     = 4'h0;
        add_b     = 4'h0;
        busy      = 1'b0;
        done      = 1'b0;
        // New partial product: adder result on top, multiplier bits shifted down by one.
        sum_shift = {add_cout, add_s, p_q[3:1]};

        case (state_q)
            StIdle: begin
                if (start) begin
                    m_d     = a;
                    p_d     = {4'b0000, b};
                    cnt_d   = 2'd0;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                busy  = 1'b1;
                add_a = p_q[7:4];
                add_b = p_q[0] ? m_q : 4'h0;
                p_d   = sum_shift;
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    product_d = sum_shift;
                    state_d   = StDone;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule
